// File: rtl/sprite_datapath_pkg.sv
// Shared game constants: screen and sprite geometry, pass op codes and the
// sprite datapath state encoding. The controller FSM imports this too.
package sprite_datapath_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned SPRITE_W = 4;
  localparam int unsigned SPRITE_H = 4;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/sprite_scan_counter.sv
// 4-bit pixel scan counter for the 4x4 sprite, with synchronous clear
// (priority over enable) and a terminal-count flag at 15.
module sprite_scan_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] cnt,
  output logic       tc
);

  // Pixel index register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 4'd0;
    end else if (clr) begin
      cnt <= 4'd0;
    end else if (en) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign tc = (cnt == 4'hF);

endmodule

// File: rtl/sprite_datapath.sv
// Sprite datapath: keeps the bouncing sprite origin and, on request, scans the
// 4x4 sprite out to the VGA adapter as a draw or erase pass, one pixel per cycle.
module sprite_datapath
  import sprite_datapath_pkg::*;
#(
  parameter int unsigned X_MAX  = SCREEN_W - SPRITE_W,
  parameter int unsigned Y_MAX  = SCREEN_H - SPRITE_H,
  parameter int unsigned X_INIT = 80,
  parameter int unsigned Y_INIT = 60,
  parameter logic [2:0]  COLOUR = 3'b100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       datapath_en,
  input  logic [1:0] op,
  input  logic       load_coord,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done,
  output logic       touch_edge
);

  localparam logic [7:0] X_LIM   = 8'(X_MAX);
  localparam logic [6:0] Y_LIM   = 7'(Y_MAX);
  localparam logic [7:0] X_START = 8'(X_INIT);
  localparam logic [6:0] Y_START = 7'(Y_INIT);

  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_sel;
  logic [7:0] x_pos_q, x_pos_d;
  logic [6:0] y_pos_q, y_pos_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic [3:0] cnt;
  logic       cnt_tc;
  logic [3:0] pix_idx;
  logic       start, move;

  assign start = (state_q == ST_IDLE) && datapath_en;
  // A start wins over a coincident load_coord.
  assign move  = (state_q == ST_IDLE) && !datapath_en && load_coord;

  sprite_scan_counter u_scan_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .en      ((state_q == ST_RUN) && !cnt_tc),
    .clr     (start),
    .cnt     (cnt),
    .tc      (cnt_tc)
  );

  // Outputs are registered, so they are loaded with the pixel that will be
  // current in the next cycle: pixel 0 on the start edge, cnt+1 afterwards.
  assign pix_idx = start ? 4'd0 : cnt + 4'd1;
  // op is latched on the start edge; later changes are ignored.
  assign op_sel  = (state_q == ST_IDLE) ? op : op_q;

  // Pass sequencing: IDLE -> RUN (16 pixels) -> DONE until enable drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (datapath_en) state_d = ST_RUN;
      ST_RUN:  if (cnt_tc) state_d = ST_DONE;
      ST_DONE: if (!datapath_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next sprite origin and direction, each axis bouncing off its own limits.
  always_comb begin
    x_pos_d = x_pos_q;
    y_pos_d = y_pos_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    if (move) begin
      if (dir_x_q && (x_pos_q == X_LIM)) begin
        dir_x_d = 1'b0;
        x_pos_d = X_LIM - 8'd1;
      end else if (!dir_x_q && (x_pos_q == 8'd0)) begin
        dir_x_d = 1'b1;
        x_pos_d = 8'd1;
      end else begin
        x_pos_d = dir_x_q ? x_pos_q + 8'd1 : x_pos_q - 8'd1;
      end
      if (dir_y_q && (y_pos_q == Y_LIM)) begin
        dir_y_d = 1'b0;
        y_pos_d = Y_LIM - 7'd1;
      end else if (!dir_y_q && (y_pos_q == 7'd0)) begin
        dir_y_d = 1'b1;
        y_pos_d = 7'd1;
      end else begin
        y_pos_d = dir_y_q ? y_pos_q + 7'd1 : y_pos_q - 7'd1;
      end
    end
  end

  // State, latched op and sprite position.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_DRAW;
      x_pos_q <= X_START;
      y_pos_q <= Y_START;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (start) op_q <= op;
      x_pos_q <= x_pos_d;
      y_pos_q <= y_pos_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
    end
  end

  // Registered VGA pixel outputs and handshake flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'b000;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      plot <= (state_d == ST_RUN);
      done <= (state_d == ST_DONE);
      if (state_d == ST_RUN) begin
        x      <= x_pos_q + {6'd0, pix_idx[1:0]};
        y      <= y_pos_q + {5'd0, pix_idx[3:2]};
        colour <= (op_sel == OP_DRAW) ? COLOUR : 3'b000;
      end
    end
  end

  assign touch_edge = (x_pos_q == 8'd0) || (x_pos_q == X_LIM) ||
                      (y_pos_q == 7'd0) || (y_pos_q == Y_LIM);

endmodule

// File: doc/sprite_datapath.md
SPRITE_DATAPATH -- requirements
Module: sprite_datapath

Interface
REQ-001 Parameter X_MAX, default 156, meaning the largest legal sprite x origin (160-pixel screen minus the 4-pixel sprite width).
REQ-002 Parameter Y_MAX, default 116, meaning the largest legal sprite y origin (120-pixel screen minus the 4-pixel sprite height).
REQ-003 Parameter X_INIT, default 80, meaning the x origin after reset.
REQ-004 Parameter Y_INIT, default 60, meaning the y origin after reset.
REQ-005 Parameter COLOUR, default 3'b100, meaning the draw colour.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 datapath_en  input  1  controller request to run one draw or erase pass.
REQ-009 op  input  2  pass type: 00 = draw, 01 = erase, 10/11 = treated as erase.
REQ-010 load_coord  input  1  single-cycle request to advance the sprite position by one step.
REQ-011 x  output  8  pixel x coordinate to the VGA adapter.
REQ-012 y  output  7  pixel y coordinate to the VGA adapter.
REQ-013 colour  output  3  pixel colour to the VGA adapter.
REQ-014 plot  output  1  pixel write strobe to the VGA adapter.
REQ-015 done  output  1  pass complete, returned to the controller.
REQ-016 touch_edge  output  1  sprite origin lies on a screen boundary.

Function
REQ-017 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-018 IDLE SHALL go to RUN when datapath_en=1; that same edge SHALL latch op and clear the 4-bit pixel counter cnt.
REQ-019 In RUN, plot SHALL be 1 on every cycle, with x = x_pos + cnt[1:0], y = y_pos + cnt[3:2], and colour = COLOUR for draw or 3'b000 for erase; all of these outputs SHALL be registered.
REQ-020 RUN SHALL last exactly 16 cycles (cnt 0..15, row-major order), then go to DONE.
REQ-021 The first plot cycle SHALL be the cycle after datapath_en is first sampled high.
REQ-022 In DONE, plot SHALL be 0 and done SHALL be 1.
REQ-023 DONE SHALL hold until datapath_en is sampled 0, then go to IDLE (four-phase handshake).
REQ-024 done SHALL be 0 in every state other than DONE.
REQ-025 datapath_en dropping while in RUN SHALL NOT abort the pass.
REQ-026 A change of op during RUN or DONE SHALL have no effect on the pass in progress.
REQ-027 load_coord SHALL take effect only in IDLE with datapath_en=0; in any other state, or when it coincides with a start, it SHALL be ignored.
REQ-028 Movement SHALL be ±1 per load_coord on each axis, using direction bits dir_x (1 = right) and dir_y (1 = down).
REQ-029 Edge bounce: x_pos=X_MAX with dir_x=1 SHALL clear dir_x and give x_pos=X_MAX-1; x_pos=0 with dir_x=0 SHALL set dir_x and give x_pos=1; the y axis SHALL behave the same way against Y_MAX.
REQ-030 Both axes SHALL update independently on the same edge.
REQ-031 touch_edge SHALL be combinational from the registered position: 1 when x_pos is 0 or X_MAX, or y_pos is 0 or Y_MAX.

Reset
REQ-032 reset_n=0 SHALL immediately force state=IDLE, cnt=0, plot=0, done=0, x=0, y=0, colour=0, x_pos=X_INIT, y_pos=Y_INIT, dir_x=1, dir_y=1, including when asserted mid-pass.
REQ-033 After reset is released, the next pass SHALL start at cnt=0.

Structure
REQ-034 Op codes (OP_DRAW, OP_ERASE), the screen dimensions and the sprite size SHALL live in the shared game constants package, also used by the controller FSM.
REQ-035 The design SHALL contain one sub-module, sprite_scan_counter, holding the 4-bit counter with enable, clear and a terminal-count output.

Verification
REQ-036 Reset, then datapath_en=1, op=00: plot high for 16 cycles covering x 80..83, y 60..63 row-major with colour 100; done=1 from cycle 17 until datapath_en=0, then IDLE.
REQ-037 op=01: the same 16 coordinates with colour 000; done handshake identical.
REQ-038 Force x_pos=156, dir_x=1, then pulse load_coord: x_pos=155, dir_x=0; touch_edge=1 before the pulse and 0 after (y not on an edge).
REQ-039 Position (0,0) moving left/up, pulse load_coord: position (1,1), dir_x=1, dir_y=1.
REQ-040 load_coord pulsed at RUN cycle 5 and again in DONE: position unchanged, pass unaffected.
REQ-041 reset_n=0 at RUN cycle 7: plot=0 and done=0 asynchronously, position (80,60); the following pass emits all 16 pixels starting from (80,60).
